// File: rtl/result_checker.sv
// result_checker: end-of-test checker that sits beside the CPU top.
// Waits for the committed PC to reach the program-end address, then reads
// the answer region one word at a time through a single-outstanding read
// port and compares each word with a golden source. A cycle budget counted
// from reset release forces a terminal timeout state if the run overstays.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for the end-of-program PC; budget counting
//   REQ    | read request for word idx held until granted
//   WAIT   | request accepted, waiting for read data to compare
//   DONE   | sweep complete; pass/err outputs final (terminal)
//   TOUT   | budget exhausted; any outstanding read abandoned (terminal)
module result_checker #(
    parameter int                XLEN      = 64,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ANS_BASE  = 32'h9000,
    parameter int                MAX_WORDS = 128,
    parameter logic [XLEN-1:0]   DONE_PC   = 64'h1c,
    parameter int                TIMEOUT   = 10000,
    parameter int                CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              pc_valid_i,
    input  logic [CW-1:0]     num_words_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CW-1:0]     gold_idx_o,
    input  logic [DATA_W-1:0] gold_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [CW-1:0]     err_cnt_o,
    output logic              first_err_valid_o,
    output logic [CW-1:0]     first_err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_TOUT = 3'd4
    } state_e;

    // Budget counter only needs to reach TIMEOUT-1 before the state leaves
    // the counting states, so it never wraps.
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] CYC_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);

    state_e        state_q, state_d;
    logic [TW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [CW-1:0] fei_q, fei_d;
    logic          fev_q, fev_d;

    logic          running;
    logic          expired;
    logic          trigger;
    logic          last_word;
    logic          mismatch;
    logic [CW-1:0] n_clamp;

    assign running   = (state_q == S_IDLE) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign expired   = running && (cyc_q == CYC_LAST);
    assign trigger   = (state_q == S_IDLE) && pc_valid_i && (pc_i == DONE_PC);
    assign n_clamp   = (num_words_i > MAX_CNT) ? MAX_CNT : num_words_i;
    assign last_word = (idx_q == (n_q - CW'(1)));
    assign mismatch  = (mem_rdata_i != gold_data_i);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; budget expiry overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = (n_clamp == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = last_word ? S_DONE : S_REQ;
                end
            end
            S_DONE: state_d = S_DONE;
            S_TOUT: state_d = S_TOUT;
            default: state_d = S_IDLE;
        endcase
        if (expired) begin
            state_d = S_TOUT;
        end
    end

    // Output decode from the current state.
    always_comb begin
        mem_req_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        pass_o    = 1'b0;
        timeout_o = 1'b0;
        unique case (state_q)
            S_REQ: begin
                mem_req_o = 1'b1;
                busy_o    = 1'b1;
            end
            S_WAIT: begin
                busy_o = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
                pass_o = (err_cnt_q == '0);
            end
            S_TOUT: begin
                done_o    = 1'b1;
                timeout_o = 1'b1;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Datapath next values. A cycle that expires the budget leaves the
    // sweep bookkeeping untouched so the timeout snapshot is consistent.
    always_comb begin
        cyc_d     = running ? (cyc_q + TW'(1)) : cyc_q;
        idx_d     = idx_q;
        n_d       = n_q;
        err_cnt_d = err_cnt_q;
        fei_d     = fei_q;
        fev_d     = fev_q;
        if (!expired) begin
            unique case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        n_d   = n_clamp;
                        idx_d = '0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (mismatch) begin
                            if (err_cnt_q != MAX_CNT) begin
                                err_cnt_d = err_cnt_q + CW'(1);
                            end
                            if (!fev_q) begin
                                fev_d = 1'b1;
                                fei_d = idx_q;
                            end
                        end
                        if (!last_word) begin
                            idx_d = idx_q + CW'(1);
                        end
                    end
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q     <= '0;
            idx_q     <= '0;
            n_q       <= '0;
            err_cnt_q <= '0;
            fei_q     <= '0;
            fev_q     <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            err_cnt_q <= err_cnt_d;
            fei_q     <= fei_d;
            fev_q     <= fev_d;
        end
    end

    // Word address wraps in ADDR_W bits by construction of the sum.
    assign mem_addr_o        = ANS_BASE + ADDR_W'({idx_q, 2'b00});
    assign gold_idx_o        = idx_q;
    assign err_cnt_o         = err_cnt_q;
    assign first_err_valid_o = fev_q;
    assign first_err_idx_o   = fei_q;

endmodule

// File: tb/tb_result_checker.sv
// Testbench for result_checker: scoreboard of expected read addresses and
// expected end-of-sweep results, checked by a monitor decoupled from stimulus.
module tb_result_checker;

    localparam int CW = 8;

    logic        clk;
    int          tb_cyc = 0;
    int          n_vec  = 0;
    int          n_err  = 0;

    // Main instance (default budget).
    logic        rst;
    logic [63:0] pc;
    logic        pc_valid;
    logic [CW-1:0] num_words;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [CW-1:0] gold_idx;
    logic [31:0] gold_data;
    logic        busy, done, pass, tout;
    logic [CW-1:0] err_cnt;
    logic        fev;
    logic [CW-1:0] fei;

    // Short-budget instance.
    logic        t_rst;
    logic [63:0] t_pc;
    logic        t_pc_valid;
    logic [CW-1:0] t_num;
    logic        t_req;
    logic [31:0] t_addr;
    logic        t_gnt;
    logic        t_rvalid;
    logic [31:0] t_rdata;
    logic [CW-1:0] t_gidx;
    logic [31:0] t_gdata;
    logic        t_busy, t_done, t_pass, t_tout;
    logic [CW-1:0] t_err;
    logic        t_fev;
    logic [CW-1:0] t_fei;

    logic [31:0] gold [0:255];
    logic [31:0] mem  [0:255];

    int gnt_dly = 0;
    int rv_dly  = 1;

    typedef struct {
        logic pass;
        int   err;
        logic fev;
        int   fei;
        int   done_cyc;
    } res_t;

    logic [31:0] exp_addr_q [$];
    res_t        exp_res_q  [$];

    assign gold_data = gold[gold_idx];

    result_checker dut (
        .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pc_valid), .num_words_i(num_words),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .gold_idx_o(gold_idx), .gold_data_i(gold_data),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tout),
        .err_cnt_o(err_cnt), .first_err_valid_o(fev), .first_err_idx_o(fei)
    );

    result_checker #(.TIMEOUT(50)) dut_to (
        .clk(clk), .rst(t_rst), .pc_i(t_pc), .pc_valid_i(t_pc_valid), .num_words_i(t_num),
        .mem_req_o(t_req), .mem_addr_o(t_addr), .mem_gnt_i(t_gnt),
        .mem_rvalid_i(t_rvalid), .mem_rdata_i(t_rdata),
        .gold_idx_o(t_gidx), .gold_data_i(t_gdata),
        .busy_o(t_busy), .done_o(t_done), .pass_o(t_pass), .timeout_o(t_tout),
        .err_cnt_o(t_err), .first_err_valid_o(t_fev), .first_err_idx_o(t_fei)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: grant after gnt_dly cycles, data rv_dly cycles later.
    initial begin
        int a;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            if (rst === 1'b1 && mem_req === 1'b1) begin
                a = int'((mem_addr - 32'h9000) >> 2);
                for (int i = 0; i < gnt_dly; i++) @(negedge clk);
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                for (int i = 1; i < rv_dly; i++) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = mem[a & 255];
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: pops expected addresses on each new request and expected
    // results when done rises; checks address stability while req is held.
    initial begin
        logic        prev_req;
        logic        prev_done;
        logic [31:0] held;
        logic [31:0] ea;
        res_t        r;
        prev_req  = 1'b0;
        prev_done = 1'b0;
        held      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1) begin
                prev_req  = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_req: got request addr 0x%0h, expected none", mem_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        chk("req_addr", mem_addr, ea);
                    end
                    held = mem_addr;
                end else if (mem_req && prev_req) begin
                    chk("addr_stable", mem_addr, held);
                end
                if (done && !prev_done) begin
                    if (exp_res_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=1, expected no completion");
                    end else begin
                        r = exp_res_q.pop_front();
                        chk("pass", pass, r.pass);
                        chk("err_cnt", err_cnt, r.err);
                        chk("first_err_valid", fev, r.fev);
                        chk("first_err_idx", fei, r.fei);
                        chk("timeout_flag", tout, 0);
                        if (r.done_cyc >= 0) chk("done_cycle", tb_cyc, r.done_cyc);
                    end
                end
                prev_req  = mem_req;
                prev_done = done;
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timeout"}, tout, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_fev"}, fev, 0);
        chk({tag, "_fei"}, fei, 0);
        chk({tag, "_gold_idx"}, gold_idx, 0);
        chk({tag, "_addr"}, mem_addr, 32'h9000);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; pushes the hand-computed expectations, then
    // presents the end PC for one cycle.
    task automatic start(input int n, input logic e_pass, input int e_err,
                         input logic e_fev, input int e_fei, input int lat);
        res_t r;
        int   m;
        m = (n > 128) ? 128 : n;
        for (int i = 0; i < m; i++) exp_addr_q.push_back(32'h9000 + 32'(4 * i));
        r.pass     = e_pass;
        r.err      = e_err;
        r.fev      = e_fev;
        r.fei      = e_fei;
        r.done_cyc = (lat < 0) ? -1 : tb_cyc + lat;
        exp_res_q.push_back(r);
        pc        = 64'h1c;
        pc_valid  = 1'b1;
        num_words = CW'(n);
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
        pc       = '0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_done_reached"}, done, 1);
        @(posedge clk);
        #1;
        chk({tag, "_addr_q_empty"}, exp_addr_q.size(), 0);
        chk({tag, "_res_q_empty"}, exp_res_q.size(), 0);
    endtask

    task automatic restore_mem();
        for (int i = 0; i < 256; i++) mem[i] = gold[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = 32'(i + 1);
        restore_mem();
        rst = 1'b0; pc = '0; pc_valid = 1'b0; num_words = '0;
        t_rst = 1'b0; t_pc = '0; t_pc_valid = 1'b0; t_num = '0;
        t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = 32'h6; t_gdata = 32'h5;
        #3;
        chk_idle("reset");

        // Match, with non-trigger PC noise first.
        do_reset();
        pc = 64'h1c; pc_valid = 1'b0;
        @(posedge clk); #1;
        pc = 64'h20; pc_valid = 1'b1;
        @(posedge clk); #1;
        pc_valid = 1'b0; pc = '0;
        @(posedge clk); #1;
        chk("noise_busy", busy, 0);
        start(4, 1'b1, 0, 1'b0, 0, 9);
        wait_done(40, "match");
        // Trigger after completion must be ignored.
        pc = 64'h1c; pc_valid = 1'b1;
        @(posedge clk); #1;
        pc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("retrig_done", done, 1);
        chk("retrig_busy", busy, 0);
        chk("retrig_pass", pass, 1);

        // Mismatch on words 2 and 3.
        do_reset();
        mem[2] = 32'hDEAD;
        mem[3] = 32'h0;
        start(4, 1'b0, 2, 1'b1, 2, 9);
        wait_done(40, "mismatch");
        restore_mem();

        // Back-pressure: 9 cycles per word, done 37 cycles after trigger.
        do_reset();
        gnt_dly = 3;
        rv_dly  = 5;
        start(4, 1'b1, 0, 1'b0, 0, 37);
        wait_done(80, "backpressure");
        gnt_dly = 0;
        rv_dly  = 1;

        // Empty sweep.
        do_reset();
        start(0, 1'b1, 0, 1'b0, 0, 1);
        wait_done(10, "empty");

        // Clamp 200 -> 128 words; only the last word mismatches.
        do_reset();
        mem[127] = 32'hFFFF_0000;
        start(200, 1'b0, 1, 1'b1, 127, 257);
        wait_done(400, "clamp");
        restore_mem();

        // Reset during WAIT at index 3, after errors have accumulated.
        do_reset();
        mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0;
        start(8, 1'b0, 3, 1'b1, 0, -1);
        for (int i = 0; i < 40 && !(gold_idx == 3 && busy && !mem_req); i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_abort_err_cnt", err_cnt, 3);
        #1;
        rst = 1'b0;
        #1;
        chk_idle("abort");
        exp_addr_q.delete();
        exp_res_q.delete();
        restore_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start(4, 1'b1, 0, 1'b0, 0, 9);
        wait_done(40, "rerun");

        // Short budget, no trigger: timeout visible in cycle 50.
        @(negedge clk); t_rst = 1'b1;
        repeat (49) @(posedge clk);
        #1;
        chk("to_idle_c49", t_tout, 0);
        @(posedge clk); #1;
        chk("to_idle_c50", t_tout, 1);
        chk("to_idle_done", t_done, 1);
        chk("to_idle_pass", t_pass, 0);

        // Trigger in the expiry cycle still lands in timeout.
        t_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); t_rst = 1'b1;
        repeat (49) @(posedge clk);
        #1;
        t_pc = 64'h1c; t_pc_valid = 1'b1; t_num = 8'd4;
        @(posedge clk); #1;
        t_pc_valid = 1'b0;
        chk("to_trig_timeout", t_tout, 1);
        chk("to_trig_req", t_req, 0);
        chk("to_trig_busy", t_busy, 0);

        // Expiry while a request waits for a grant that never comes.
        t_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); t_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        t_pc_valid = 1'b1;
        @(posedge clk); #1;
        t_pc_valid = 1'b0;
        chk("to_sweep_req_c11", t_req, 1);
        chk("to_sweep_addr", t_addr, 32'h9000);
        repeat (38) @(posedge clk);
        #1;
        chk("to_sweep_req_c49", t_req, 1);
        chk("to_sweep_tout_c49", t_tout, 0);
        @(posedge clk); #1;
        chk("to_sweep_req_c50", t_req, 0);
        chk("to_sweep_tout_c50", t_tout, 1);
        chk("to_sweep_pass", t_pass, 0);
        t_rvalid = 1'b1;
        @(posedge clk); #1;
        t_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("to_late_rvalid_err", t_err, 0);
        chk("to_late_rvalid_fev", t_fev, 0);
        chk("to_late_rvalid_tout", t_tout, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Synthesisable end-of-test checker for the RV64I CPU, placed beside Top.
- Watches the committed PC for the program-end address, then sweeps the answer region through a single-outstanding memory read port and compares each word against a golden-data source.
- Reports pass/fail, error count, first failing index and a cycle-budget timeout.
- Parametrised successor of the simulation-only check: configurable region, word count, PC width, end address and budget, with a real memory handshake, first-error capture, timeout while sweeping and status outputs.

Parameters:
- XLEN, 64, PC width.
- DATA_W, 32, compared word width.
- ADDR_W, 32, memory address width.
- ANS_BASE, 32'h9000, byte address of answer word 0.
- MAX_WORDS, 128, maximum words checked.
- DONE_PC, 64'h1c, PC value that ends execution.
- TIMEOUT, 10000, cycle budget counted from reset release.
- CW, $clog2(MAX_WORDS+1), width of counts and indices.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc_i  in  XLEN  current PC.
- pc_valid_i  in  1  pc_i is valid this cycle.
- num_words_i  in  CW  number of words to check; sampled at trigger.
- mem_req_o  out  1  read request.
- mem_addr_o  out  ADDR_W  read byte address.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_W  read data.
- gold_idx_o  out  CW  golden index, equal to the current word index.
- gold_data_i  in  DATA_W  golden word for gold_idx_o; combinational lookup.
- busy_o  out  1  sweep in progress.
- done_o  out  1  check finished; sticky.
- pass_o  out  1  done_o and err_cnt_o==0; sticky.
- timeout_o  out  1  budget exhausted; sticky.
- err_cnt_o  out  CW  number of mismatches.
- first_err_valid_o  out  1  first_err_idx_o holds a mismatch index.
- first_err_idx_o  out  CW  index of the first mismatch.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; cycle counter, index, word count, err_cnt_o and first_err_idx_o all 0; every 1-bit output 0; mem_addr_o = ANS_BASE.
- States: IDLE, REQ, WAIT, DONE, TOUT.
- Cycle counter:
  - Increments every cycle in IDLE, REQ and WAIT.
  - When it equals TIMEOUT-1, next state is TOUT, overriding any other transition in the same cycle, including a trigger.
- IDLE:
  - Trigger is pc_valid_i && pc_i==DONE_PC.
  - On trigger, latch n = min(num_words_i, MAX_WORDS) and set index = 0.
  - If n==0, go to DONE; otherwise go to REQ.
- REQ:
  - mem_req_o=1, mem_addr_o = ANS_BASE + 4*index; address is computed in ADDR_W bits and wraps.
  - Hold request and address stable until mem_gnt_i.
  - On gnt, go to WAIT.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, compare mem_rdata_i against gold_data_i in that same cycle.
  - On mismatch: err_cnt_o increments, saturating at MAX_WORDS. If first_err_valid_o is 0, capture index and set first_err_valid_o.
  - Then if index==n-1, go to DONE; otherwise index+1 and go to REQ.
  - mem_rvalid_i outside WAIT is ignored.
- Throughput: with gnt in the request cycle and rvalid the next cycle, one word per 2 cycles.
- Trigger at cycle T gives mem_req_o high at T+1. done_o rises the cycle after the final compare.
- DONE: done_o=1, pass_o=(err_cnt_o==0), busy_o=0. Terminal until reset.
- TOUT:
  - timeout_o=1, done_o=1, pass_o=0, mem_req_o=0. Terminal until reset.
  - Entry from REQ abandons any outstanding read; later rvalid is ignored.
- busy_o=1 exactly in REQ and WAIT.
- gold_idx_o=index at all times.
- A trigger seen in any state other than IDLE is ignored.
- Reset mid-sweep aborts immediately; the next sweep starts clean from index 0.

Test Plan:
- Match: num_words_i=4, memory = golden = {1,2,3,4}, gnt same cycle, rvalid +1, trigger at pc=0x1c. Required: addresses 0x9000, 0x9004, 0x9008, 0x900c; done_o 9 cycles after trigger; pass_o=1; err_cnt_o=0.
- Mismatch: same setup with word 2 = 0xDEAD and golden 3, plus word 3 = 0. Required: err_cnt_o=2, first_err_idx_o=2, pass_o=0, done_o=1.
- Back-pressure: gnt delayed 3 cycles and rvalid delayed 5 cycles. Required: mem_addr_o stable while req is high; exactly one request per word; result identical to the match case.
- Empty and clamp: num_words_i=0 gives done_o=1, pass_o=1 and no mem_req_o. num_words_i=200 with MAX_WORDS=128 checks exactly 128 words.
- Timeout: TIMEOUT=50 and no trigger gives timeout_o=1 at cycle 50 with pass_o=0. Trigger in the same cycle as expiry also gives TOUT. Expiry mid-sweep drops mem_req_o the next cycle.
- Reset mid-sweep: rst low during WAIT at index 3. Required: all outputs 0 asynchronously; a re-run restarts at 0x9000 with err_cnt_o=0.
